// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file sizing and encoding types
package cpu_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int ENC_W    = $clog2(NUM_REGS);

  typedef logic [ENC_W-1:0] reg_enc_t;

  localparam logic [DATA_W-1:0] RESET_VAL = 32'd3;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/write-back/debug bundle for the register file
interface regfile_scoreboard_if #(
  parameter int ENC_W  = cpu_pkg::ENC_W,
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic [ENC_W-1:0]  rd0_enc;
  logic [ENC_W-1:0]  rd1_enc;
  logic              rd0_use;
  logic              rd1_use;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic              issue_valid;
  logic              issue_we;
  logic [ENC_W-1:0]  issue_enc;
  logic              stall;
  logic              wb_we;
  logic [ENC_W-1:0]  wb_enc;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [ENC_W-1:0]  dbg_enc;
  logic [DATA_W-1:0] dbg_data;
  logic              err;

  // Pipeline side: decode, write-back and debug drive requests
  modport master (
    output rd0_enc, rd1_enc, rd0_use, rd1_use,
    output issue_valid, issue_we, issue_enc,
    output wb_we, wb_enc, wb_data, flush, dbg_enc,
    input  rd0_data, rd1_data, stall, dbg_data, err
  );

  // Register-file side
  modport slave (
    input  rd0_enc, rd1_enc, rd0_use, rd1_use,
    input  issue_valid, issue_we, issue_enc,
    input  wb_we, wb_enc, wb_data, flush, dbg_enc,
    output rd0_data, rd1_data, stall, dbg_data, err
  );

endinterface

// File: rtl/pend_counter.sv
// rtl/pend_counter.sv - per-register count of in-flight writes
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] count
);

  localparam logic [PEND_W-1:0] COUNT_MAX = '1;

  // Clear dominates; simultaneous inc/dec cancel; never wrap at either end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && count != COUNT_MAX) begin
      count <= count + 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - bypassed register file with pending-write scoreboard
module regfile_scoreboard #(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int PEND_W   = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(cpu_pkg::RESET_VAL),
  localparam int ENC_W   = $clog2(NUM_REGS)
) (
  input  logic clk,
  input  logic reset,
  regfile_scoreboard_if.slave bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                busy0;
  logic                busy1;
  logic                dfull;
  logic                stall;
  logic                accept;
  logic                err;

  // Operand is busy unless its only outstanding write is retiring right now
  always_comb begin
    busy0  = (pend[bus.rd0_enc] != '0) &&
             !(bus.wb_we && bus.wb_enc == bus.rd0_enc && pend[bus.rd0_enc] == PEND_ONE);
    busy1  = (pend[bus.rd1_enc] != '0) &&
             !(bus.wb_we && bus.wb_enc == bus.rd1_enc && pend[bus.rd1_enc] == PEND_ONE);
    dfull  = bus.issue_we && (pend[bus.issue_enc] == PEND_MAX);
    stall  = bus.issue_valid &&
             ((bus.rd0_use && busy0) || (bus.rd1_use && busy1) || dfull);
    accept = bus.issue_valid && !stall && bus.issue_we;
  end

  // Per-register increment on accepted issue, decrement on write-back of a pending value
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inc_vec[i] = accept && (bus.issue_enc == ENC_W'(i));
      dec_vec[i] = bus.wb_we && (bus.wb_enc == ENC_W'(i)) && (pend[i] != '0);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    pend_counter #(.PEND_W(PEND_W)) u_pend (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_vec[g]),
      .dec   (dec_vec[g]),
      .clr   (bus.flush),
      .count (pend[g])
    );
  end

  // Write-back always lands in storage, independent of flush and counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (bus.wb_we) begin
      regs[bus.wb_enc] <= bus.wb_data;
    end
  end

  // Sticky flag for a write-back nobody was waiting for
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (bus.wb_we && pend[bus.wb_enc] == '0 && !bus.flush) begin
      err <= 1'b1;
    end
  end

  assign bus.rd0_data = (bus.wb_we && bus.wb_enc == bus.rd0_enc) ? bus.wb_data : regs[bus.rd0_enc];
  assign bus.rd1_data = (bus.wb_we && bus.wb_enc == bus.rd1_enc) ? bus.wb_data : regs[bus.rd1_enc];
  assign bus.dbg_data = regs[bus.dbg_enc];
  assign bus.stall    = stall;
  assign bus.err      = err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and randomized checks against a reference model
module tb_regfile_scoreboard;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(.ENC_W(ENC_W), .DATA_W(DATA_W)) bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: register values, outstanding write counts, sticky error
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  int                m_pend [NUM_REGS];
  bit                m_err;
  localparam int PMAX = 3;

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = RESET_VAL;
      m_pend[i] = 0;
    end
    m_err = 0;
  endtask

  function automatic bit m_busy(int e);
    return m_pend[e] != 0 && !(bus.wb_we && int'(bus.wb_enc) == e && m_pend[e] == 1);
  endfunction

  function automatic bit m_stall();
    bit df;
    df = bus.issue_we && m_pend[bus.issue_enc] == PMAX;
    return bus.issue_valid && ((bus.rd0_use && m_busy(int'(bus.rd0_enc))) ||
                               (bus.rd1_use && m_busy(int'(bus.rd1_enc))) || df);
  endfunction

  function automatic logic [DATA_W-1:0] m_rd(reg_enc_t e);
    return (bus.wb_we && bus.wb_enc == e) ? bus.wb_data : m_regs[e];
  endfunction

  task automatic idle();
    bus.rd0_enc = '0; bus.rd1_enc = '0; bus.rd0_use = 0; bus.rd1_use = 0;
    bus.issue_valid = 0; bus.issue_we = 0; bus.issue_enc = '0;
    bus.wb_we = 0; bus.wb_enc = '0; bus.wb_data = '0; bus.flush = 0; bus.dbg_enc = '0;
  endtask

  // Advance one clock and apply the architectural effect of the current inputs
  task automatic tick();
    int  np [NUM_REGS];
    bit  acc;
    acc = bus.issue_valid && !m_stall() && bus.issue_we;
    for (int i = 0; i < NUM_REGS; i++) np[i] = m_pend[i];
    if (bus.flush) begin
      for (int i = 0; i < NUM_REGS; i++) np[i] = 0;
    end else begin
      if (acc) np[bus.issue_enc] += 1;
      if (bus.wb_we && m_pend[bus.wb_enc] != 0) np[bus.wb_enc] -= 1;
    end
    @(posedge clk);
    if (bus.wb_we) begin
      if (m_pend[bus.wb_enc] == 0 && !bus.flush) m_err = 1;
      m_regs[bus.wb_enc] = bus.wb_data;
    end
    for (int i = 0; i < NUM_REGS; i++) m_pend[i] = np[i];
    @(negedge clk);
  endtask

  task automatic issue_write(reg_enc_t e);
    idle();
    bus.issue_valid = 1; bus.issue_we = 1; bus.issue_enc = e;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++; $display("FAIL issue_accept reg=%0d stall=%b want 0", e, bus.stall);
    end
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    m_reset();
    #1;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.dbg_enc = reg_enc_t'(i);
      #1;
      checks++;
      if (bus.dbg_data !== RESET_VAL) begin
        failures++; $display("FAIL reset_dbg reg=%0d got=%h want=%h", i, bus.dbg_data, RESET_VAL);
      end
    end
    bus.issue_valid = 1; bus.rd0_use = 1; bus.rd1_use = 1; bus.rd1_enc = 2'd3;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want 0", bus.stall); end
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want 0", bus.err); end
    checks++;
    if (bus.rd1_data !== RESET_VAL) begin
      failures++; $display("FAIL reset_rd1 got=%h want=%h", bus.rd1_data, RESET_VAL);
    end
    @(negedge clk);
    reset = 0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_bypass();
    issue_write(2'd1);
    idle();
    bus.wb_we = 1; bus.wb_enc = 2'd1; bus.wb_data = 32'h55; bus.rd0_enc = 2'd1;
    #1;
    checks++;
    if (bus.rd0_data !== 32'h55) begin failures++; $display("FAIL bypass_same got=%h want=55", bus.rd0_data); end
    tick();
    idle();
    bus.rd0_enc = 2'd1;
    #1;
    checks++;
    if (bus.rd0_data !== 32'h55) begin failures++; $display("FAIL bypass_storage got=%h want=55", bus.rd0_data); end
  endtask

  task automatic test_hazard();
    issue_write(2'd2);
    idle();
    bus.issue_valid = 1; bus.rd0_enc = 2'd2; bus.rd0_use = 1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL hazard_stall got=%b want 1", bus.stall); end
    bus.rd0_use = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL hazard_unused got=%b want 0", bus.stall); end
    tick();
    bus.rd0_use = 1; bus.wb_we = 1; bus.wb_enc = 2'd2; bus.wb_data = 32'h77;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL hazard_wb_stall got=%b want 0", bus.stall); end
    checks++;
    if (bus.rd0_data !== 32'h77) begin failures++; $display("FAIL hazard_wb_data got=%h want=77", bus.rd0_data); end
    tick();
  endtask

  task automatic test_waw();
    issue_write(2'd0);
    issue_write(2'd0);
    idle();
    bus.issue_valid = 1; bus.rd0_enc = 2'd0; bus.rd0_use = 1;
    bus.wb_we = 1; bus.wb_enc = 2'd0; bus.wb_data = 32'h100;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL waw_first_wb got=%b want 1", bus.stall); end
    tick();
    bus.wb_data = 32'h200;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL waw_last_wb got=%b want 0", bus.stall); end
    checks++;
    if (bus.rd0_data !== 32'h200) begin failures++; $display("FAIL waw_bypass got=%h want=200", bus.rd0_data); end
    tick();
    bus.wb_we = 0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.rd0_data !== 32'h200) begin
      failures++; $display("FAIL waw_after stall=%b data=%h want 0/200", bus.stall, bus.rd0_data);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) issue_write(2'd3);
    idle();
    bus.issue_valid = 1; bus.issue_we = 1; bus.issue_enc = 2'd3;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL sat_fourth got=%b want 1", bus.stall); end
    tick();
    // Drain: a count held at 3 stalls a reader on the first two write-backs only
    for (int k = 0; k < 3; k++) begin
      idle();
      bus.issue_valid = 1; bus.rd1_enc = 2'd3; bus.rd1_use = 1;
      bus.wb_we = 1; bus.wb_enc = 2'd3; bus.wb_data = 32'h300 + k;
      #1;
      checks++;
      if (bus.stall !== (k < 2)) begin
        failures++; $display("FAIL sat_drain step=%0d got=%b want %b", k, bus.stall, k < 2);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL sat_no_err got=%b want 0", bus.err); end
  endtask

  task automatic test_err();
    idle();
    bus.wb_we = 1; bus.wb_enc = 2'd1; bus.wb_data = 32'hA5A5;
    tick();
    idle();
    bus.dbg_enc = 2'd1;
    #1;
    checks++;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want 1", bus.err); end
    checks++;
    if (bus.dbg_data !== 32'hA5A5) begin failures++; $display("FAIL err_data got=%h want=a5a5", bus.dbg_data); end
  endtask

  task automatic test_flush();
    issue_write(2'd0);
    issue_write(2'd1);
    idle();
    bus.flush = 1; bus.issue_valid = 1; bus.issue_we = 1; bus.issue_enc = 2'd2;
    tick();
    for (int r = 0; r < 3; r++) begin
      idle();
      bus.issue_valid = 1; bus.rd0_enc = reg_enc_t'(r); bus.rd0_use = 1;
      #1;
      checks++;
      if (bus.stall !== 1'b0) begin failures++; $display("FAIL flush_clear reg=%0d got=%b want 0", r, bus.stall); end
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    issue_write(2'd2);
    idle();
    bus.issue_valid = 1; bus.rd0_enc = 2'd2; bus.rd0_use = 1; bus.dbg_enc = 2'd2;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b want 1", bus.stall); end
    #1;
    reset = 1;
    m_reset();
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b want 0", bus.stall); end
    checks++;
    if (bus.dbg_data !== RESET_VAL || bus.err !== 1'b0) begin
      failures++; $display("FAIL midrst_state dbg=%h err=%b want %h/0", bus.dbg_data, bus.err, RESET_VAL);
    end
    @(negedge clk);
    reset = 0;
    idle();
    @(negedge clk);
  endtask

  task automatic test_random();
    int cand [$];
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.rd0_enc = reg_enc_t'($urandom_range(0, NUM_REGS - 1));
      bus.rd1_enc = reg_enc_t'($urandom_range(0, NUM_REGS - 1));
      bus.rd0_use = 1'($urandom);
      bus.rd1_use = 1'($urandom);
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      bus.issue_we = 1'($urandom);
      bus.issue_enc = reg_enc_t'($urandom_range(0, NUM_REGS - 1));
      bus.dbg_enc = reg_enc_t'($urandom_range(0, NUM_REGS - 1));
      bus.flush = ($urandom_range(0, 39) == 0);
      bus.wb_data = $urandom;
      cand.delete();
      for (int i = 0; i < NUM_REGS; i++) if (m_pend[i] != 0) cand.push_back(i);
      if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
        bus.wb_we = 1;
        bus.wb_enc = reg_enc_t'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 49) == 0) begin
        bus.wb_we = 1;
        bus.wb_enc = reg_enc_t'($urandom_range(0, NUM_REGS - 1));
      end
      #1;
      checks++;
      if (bus.stall !== m_stall()) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%b want %b", n, bus.stall, m_stall());
      end
      checks++;
      if (bus.rd0_data !== m_rd(bus.rd0_enc) || bus.rd1_data !== m_rd(bus.rd1_enc)) begin
        failures++; $display("FAIL rnd_rd cyc=%0d got=%h/%h want %h/%h", n, bus.rd0_data, bus.rd1_data,
                             m_rd(bus.rd0_enc), m_rd(bus.rd1_enc));
      end
      checks++;
      if (bus.dbg_data !== m_regs[bus.dbg_enc] || bus.err !== m_err) begin
        failures++; $display("FAIL rnd_dbg cyc=%0d got=%h/%b want %h/%b", n, bus.dbg_data, bus.err,
                             m_regs[bus.dbg_enc], m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1;
    idle();
    m_reset();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_hazard();
    test_waw();
    test_saturation();
    test_err();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
